// File: rtl/adder_gear_ecu.sv
// GeAr approximate adder with an optional multi-cycle correction pass that makes the sum exact.
// Latency: 1 cycle approximate, K cycles exact; one operation in flight, result held until out_ready.
module adder_gear_ecu #(
  parameter int R       = 4,
  parameter int P       = 4,
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16,
  localparam int BITS   = (WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B,
  localparam int L      = R + P,
  localparam int K      = 1 + (BITS - L + R - 1) / R,
  localparam int N      = L + (K - 1) * R,
  localparam int CW     = $clog2(K + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] A,
  input  logic [WIDTH_B-1:0] B,
  input  logic               exact_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITS-1:0]    OUT,
  output logic               err_flag,
  output logic [CW-1:0]      corr_cnt
);

  // The top R operand bits only feed the last window's approximate sum,
  // which is formed at accept, so they are never revisited.
  localparam int NK = N - R;

  typedef enum logic [1:0] {IDLE, CORRECT, DONE} state_t;

  state_t          state_q, state_d;
  logic [NK-1:0]   a_q, a_d, b_q, b_d;
  logic [N-1:0]    s_q, s_d;
  logic            c_q, c_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_out_q, cnt_out_d;
  logic [BITS-1:0] out_q, out_d;
  logic            err_q, err_d;

  logic [N-1:0]    a_ext, b_ext, s_apx;
  logic [L-1:0]    w;
  logic [NK-1:0]   x;
  int              pos;
  logic            ci, pi;

  always_comb begin
    a_ext = N'(signed'(A));
    b_ext = N'(signed'(B));
  end

  always_comb begin
    s_apx = '0;
    w     = '0;
    for (int i = 0; i < K; i++) begin
      w = a_ext[i*R +: L] + b_ext[i*R +: L];
      if (i == 0) s_apx[L-1:0] = w;
      else        s_apx[P + i*R +: R] = w[L-1:P];
    end
  end

  // Carry into window idx's prediction bits, and whether it propagates past them.
  always_comb begin
    x   = a_q ^ b_q;
    pos = (idx_q == '0) ? R : int'(idx_q) * R;
    ci  = |(({1'b0, a_q[pos-R +: R]} + {1'b0, b_q[pos-R +: R]} + (R+1)'(c_q)) >> R);
    pi  = &x[pos +: P];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    c_d       = c_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    cnt_out_d = cnt_out_q;
    out_d     = out_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d   = a_ext[NK-1:0];
          b_d   = b_ext[NK-1:0];
          s_d   = s_apx;
          c_d   = 1'b0;
          idx_d = CW'(1);
          cnt_d = '0;
          if (!exact_en || K == 1) begin
            state_d   = DONE;
            out_d     = s_apx[BITS-1:0];
            err_d     = 1'b0;
            cnt_out_d = '0;
          end else begin
            state_d = CORRECT;
          end
        end
      end
      CORRECT: begin
        if (ci && pi) begin
          s_d[pos+P +: R] = s_q[pos+P +: R] + R'(1);
          cnt_d           = cnt_q + CW'(1);
        end
        c_d   = ci;
        idx_d = idx_q + CW'(1);
        if (idx_q == CW'(K - 1)) begin
          state_d   = DONE;
          out_d     = s_d[BITS-1:0];
          cnt_out_d = cnt_d;
          err_d     = (cnt_d != '0);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      c_q       <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      cnt_out_q <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s_q       <= s_d;
      c_q       <= c_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      cnt_out_q <= cnt_out_d;
      out_q     <= out_d;
      err_q     <= err_d;
    end
  end

  assign OUT      = out_q;
  assign err_flag = err_q;
  assign corr_cnt = cnt_out_q;

endmodule

// File: tb/tb_adder_gear_ecu.sv
// Bench for adder_gear_ecu: directed vectors plus scoreboarded random traffic on 16/16 and 8/16 instances.
module tb_adder_gear_ecu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, exact_en = 1'b0, out_valid, out_ready = 1'b1, err_flag;
  logic [15:0] A = '0, B = '0, OUT;
  logic [1:0]  corr_cnt;

  logic        in_valid8 = 1'b0, in_ready8, exact_en8 = 1'b0, out_valid8, out_ready8 = 1'b1, err_flag8;
  logic [7:0]  A8 = '0;
  logic [15:0] B8 = '0, OUT8;
  logic [1:0]  corr_cnt8;

  adder_gear_ecu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .exact_en(exact_en), .out_valid(out_valid), .out_ready(out_ready),
    .OUT(OUT), .err_flag(err_flag), .corr_cnt(corr_cnt)
  );

  adder_gear_ecu #(.WIDTH_A(8), .WIDTH_B(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .B(B8), .exact_en(exact_en8), .out_valid(out_valid8), .out_ready(out_ready8),
    .OUT(OUT8), .err_flag(err_flag8), .corr_cnt(corr_cnt8)
  );

  typedef struct {
    logic [15:0] o;
    logic [1:0]  c;
  } exp_t;

  exp_t sb16[$];
  exp_t sb8[$];
  int   checks = 0;
  int   errors = 0;
  bit   rnd16 = 1'b0, rnd8 = 1'b0;
  exp_t e16, e8;

  function automatic logic [15:0] model_out(input logic [15:0] a, input logic [15:0] b, input logic e);
    logic [15:0] s;
    logic [7:0]  w;
    if (e) return a + b;
    s      = '0;
    w      = a[7:0] + b[7:0];
    s[7:0] = w;
    for (int i = 1; i < 3; i++) begin
      w = a[i*4 +: 8] + b[i*4 +: 8];
      s[4 + i*4 +: 4] = w[7:4];
    end
    return s;
  endfunction

  function automatic logic [1:0] model_cnt(input logic [15:0] a, input logic [15:0] b, input logic e);
    logic [16:0] full, cy;
    logic [15:0] x;
    logic [1:0]  n;
    if (!e) return 2'd0;
    full = {1'b0, a} + {1'b0, b};
    cy   = full ^ {1'b0, a} ^ {1'b0, b};
    x    = a ^ b;
    n    = '0;
    for (int i = 1; i < 3; i++)
      if (cy[i*4] && (&x[i*4 +: 4])) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rnd16) out_ready  = 1'($urandom_range(0, 1));
    if (rnd8)  out_ready8 = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb16.size() == 0) begin
        errors++;
        $display("FAIL mon16_spurious: out_valid with OUT=%h but nothing expected", OUT);
      end else begin
        e16 = sb16.pop_front();
        if (OUT !== e16.o || corr_cnt !== e16.c || err_flag !== (e16.c != 2'd0)) begin
          errors++;
          $display("FAIL mon16_result: got OUT=%h cnt=%0d err=%b, want OUT=%h cnt=%0d err=%b",
                   OUT, corr_cnt, err_flag, e16.o, e16.c, (e16.c != 2'd0));
        end
      end
    end
    if (rst_n && out_valid8 && out_ready8) begin
      checks++;
      if (sb8.size() == 0) begin
        errors++;
        $display("FAIL mon8_spurious: out_valid with OUT=%h but nothing expected", OUT8);
      end else begin
        e8 = sb8.pop_front();
        if (OUT8 !== e8.o || corr_cnt8 !== e8.c || err_flag8 !== (e8.c != 2'd0)) begin
          errors++;
          $display("FAIL mon8_result: got OUT=%h cnt=%0d err=%b, want OUT=%h cnt=%0d err=%b",
                   OUT8, corr_cnt8, err_flag8, e8.o, e8.c, (e8.c != 2'd0));
        end
      end
    end
  end

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic e,
                        input logic [15:0] eo, input logic [1:0] ec, input bit wait_out, output int lat);
    int n;
    lat = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; A = a; B = b; exact_en = e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send16_timeout: in_ready=%b, want 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    sb16.push_back('{eo, ec});
    @(posedge clk); #1;
    in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom); exact_en = ~e;
    if (wait_out) begin
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    end
  endtask

  task automatic send8(input logic [7:0] a, input logic [15:0] b, input logic e);
    int n;
    logic [15:0] ax;
    ax = {{8{a[7]}}, a};
    @(posedge clk); #1;
    in_valid8 = 1'b1; A8 = a; B8 = b; exact_en8 = e;
    n = 0;
    @(negedge clk);
    while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
    if (!in_ready8) begin
      checks++; errors++;
      $display("FAIL send8_timeout: in_ready=%b, want 1", in_ready8);
      in_valid8 = 1'b0;
      return;
    end
    sb8.push_back('{model_out(ax, b, e), model_cnt(ax, b, e)});
    @(posedge clk); #1;
    in_valid8 = 1'b0; A8 = 8'($urandom); B8 = 16'($urandom); exact_en8 = ~e;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (OUT !== 16'h0 || corr_cnt !== 2'd0 || err_flag !== 1'b0 || out_valid !== 1'b0 || out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: OUT=%h cnt=%0d err=%b ov=%b ov8=%b, want all 0",
               OUT, corr_cnt, err_flag, out_valid, out_valid8);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b in_ready8=%b, want 1", in_ready, in_ready8);
    end
  endtask

  task automatic test_approx();
    int lat;
    send16(16'h00FF, 16'h0001, 1'b0, 16'h0000, 2'd0, 1'b1, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL approx_latency: got %0d, want 1", lat); end
    send16(16'h0FFF, 16'h0001, 1'b0, 16'h0F00, 2'd0, 1'b1, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL approx_latency2: got %0d, want 1", lat); end
  endtask

  task automatic test_exact();
    int lat;
    send16(16'h00FF, 16'h0001, 1'b1, 16'h0100, 2'd1, 1'b1, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL exact_latency: got %0d, want 3", lat); end
    send16(16'h0FFF, 16'h0001, 1'b1, 16'h1000, 2'd2, 1'b1, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL exact_latency2: got %0d, want 3", lat); end
  endtask

  task automatic test_hold();
    int lat;
    @(posedge clk); #1; out_ready = 1'b0;
    send16(16'hFFFF, 16'h0001, 1'b1, 16'h0000, 2'd2, 1'b1, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL hold_latency: got %0d, want 3", lat); end
    in_valid = 1'b1; A = 16'h1111; B = 16'h2222; exact_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || OUT !== 16'h0000 || corr_cnt !== 2'd2 || err_flag !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable: cyc %0d ov=%b ir=%b OUT=%h cnt=%0d err=%b, want 1 0 0000 2 1",
                 i, out_valid, in_ready, OUT, corr_cnt, err_flag);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    send16(16'h0FFF, 16'h0001, 1'b1, 16'h1000, 2'd2, 1'b1, lat);
    repeat (2) @(posedge clk);
    send16(16'hABCD, 16'h1111, 1'b1, 16'hBCDE, 2'd0, 1'b0, lat);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (OUT !== 16'h0 || corr_cnt !== 2'd0 || err_flag !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: OUT=%h cnt=%0d err=%b ov=%b, want all 0", OUT, corr_cnt, err_flag, out_valid);
    end
    sb16.delete();
    sb8.delete();
    #3 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b, want 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_valid: cyc %0d ov=%b, want 0", i, out_valid); end
    end
    send16(16'h1234, 16'h4321, 1'b1, 16'h5555, 2'd0, 1'b1, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL midreset_next_latency: got %0d, want 3", lat); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random16();
    int lat;
    logic [15:0] a, b;
    logic        e;
    rnd16 = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      a = 16'($urandom); b = 16'($urandom); e = 1'($urandom_range(0, 1));
      if (i < 4) begin a = 16'hFFFF; b = 16'h0001 << (4 * i); end
      send16(a, b, e, model_out(a, b, e), model_cnt(a, b, e), 1'b0, lat);
    end
    for (int n = 0; n < 100 && sb16.size() != 0; n++) @(posedge clk);
    rnd16 = 1'b0;
    checks++;
    if (sb16.size() != 0) begin errors++; $display("FAIL rand16_drain: %0d left, want 0", sb16.size()); end
  endtask

  task automatic test_random8();
    logic [7:0]  a;
    logic [15:0] b;
    rnd8 = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      a = 8'($urandom); b = 16'($urandom);
      send8(a, b, 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 100 && sb8.size() != 0; n++) @(posedge clk);
    rnd8 = 1'b0;
    checks++;
    if (sb8.size() != 0) begin errors++; $display("FAIL rand8_drain: %0d left, want 0", sb8.size()); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_approx();
    test_exact();
    test_hold();
    test_reset_mid();
    fork
      test_random16();
      test_random8();
    join
    out_ready  = 1'b1;
    out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
